// File: rtl/decode1_buffered.sv
// decode1_buffered: decodes up to FETCH_WIDTH instructions per cycle, truncates
// the packet after the first predicted-taken lane, and compacts the surviving
// lanes into a DEPTH-entry circular queue. Up to OUT_WIDTH of the oldest entries
// are presented to decode2 each cycle.
// Optional build macro: DECODE1_PERF_CNT_EN adds the saturating performance
// counters perf_full_cycles and perf_flushed_insts.

package decode1_pkg;
   typedef struct packed {
      logic [6:0]         opcode;
      logic [4:0]         rd;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [2:0]         funct3;
      logic [6:0]         funct7;
      logic signed [31:0] imm;
      logic               is_branch;
      logic               is_jump;
      logic               is_load;
      logic               is_store;
      logic               illegal;
   } decode_instruction_t;
endpackage

module decode1_buffered
   import decode1_pkg::*;
#(
   parameter int FETCH_WIDTH = 2,
   parameter int OUT_WIDTH   = 2,
   parameter int DEPTH       = 8,
   parameter int XLEN        = 32
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             clk_en,
   input  logic                                             stall,
   input  logic                                             flush_valid,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic [FETCH_WIDTH-1:0]                           in_lane_mask,
   input  logic [FETCH_WIDTH*32-1:0]                        in_inst,
   input  logic [XLEN-1:0]                                  in_pc,
   input  logic [XLEN-1:0]                                  in_pred_next_adr,
   input  logic [FETCH_WIDTH-1:0]                           in_branch_jump,
   input  logic                                             out_ready,
   output logic [OUT_WIDTH-1:0]                             out_valid,
   output logic [OUT_WIDTH*XLEN-1:0]                        out_pc,
   output logic [OUT_WIDTH*$bits(decode_instruction_t)-1:0] out_decoded,
   output logic [OUT_WIDTH*XLEN-1:0]                        out_pred_next_adr,
   output logic [OUT_WIDTH-1:0]                             out_branch_jump,
`ifdef DECODE1_PERF_CNT_EN
   output logic [31:0]                                      perf_full_cycles,
   output logic [31:0]                                      perf_flushed_insts,
`endif
   output logic [$clog2(DEPTH):0]                           occupancy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DEC_W = $bits(decode_instruction_t);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] FETCH_C = CNT_W'(FETCH_WIDTH);
   localparam logic [CNT_W-1:0] OUT_C   = CNT_W'(OUT_WIDTH);

   // One RV32 decoder per lane: field extraction, immediate formation, class flags.
   function automatic decode_instruction_t simple_decode(input logic [31:0] inst);
      decode_instruction_t d;
      d        = '0;
      d.opcode = inst[6:0];
      d.rd     = inst[11:7];
      d.funct3 = inst[14:12];
      d.rs1    = inst[19:15];
      d.rs2    = inst[24:20];
      d.funct7 = inst[31:25];
      case (inst[6:0])
         7'b0110111, 7'b0010111: d.imm = {inst[31:12], 12'b0};
         7'b1101111: begin
            d.imm     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            d.is_jump = 1'b1;
         end
         7'b1100111: begin
            d.imm     = {{20{inst[31]}}, inst[31:20]};
            d.is_jump = 1'b1;
         end
         7'b1100011: begin
            d.imm       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            d.is_branch = 1'b1;
         end
         7'b0000011: begin
            d.imm     = {{20{inst[31]}}, inst[31:20]};
            d.is_load = 1'b1;
         end
         7'b0100011: begin
            d.imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            d.is_store = 1'b1;
         end
         7'b0010011, 7'b0001111, 7'b1110011: d.imm = {{20{inst[31]}}, inst[31:20]};
         7'b0110011: d.imm = '0;
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;

   decode_instruction_t q_dec  [DEPTH];
   logic [XLEN-1:0]     q_pc   [DEPTH];
   logic [XLEN-1:0]     q_pred [DEPTH];
   logic [DEPTH-1:0]    q_bj;

   decode_instruction_t lane_dec  [FETCH_WIDTH];
   logic [XLEN-1:0]     lane_pc   [FETCH_WIDTH];
   logic [XLEN-1:0]     lane_pred [FETCH_WIDTH];
   logic [PTR_W-1:0]    wr_idx    [FETCH_WIDTH];
   logic [PTR_W-1:0]    rd_idx    [OUT_WIDTH];
   logic [FETCH_WIDTH-1:0] eff_mask;
   logic [FETCH_WIDTH-1:0] lane_taken;
   logic                cut;
   logic [CNT_W-1:0]    n_enq;
   logic [CNT_W-1:0]    n_deq;
   logic [CNT_W-1:0]    enq_cnt;
   logic [CNT_W-1:0]    deq_cnt;
   logic                enq;
   logic                deq;

   assign in_ready = (DEPTH_C - occupancy) >= FETCH_C;
   assign enq      = in_valid && in_ready && clk_en && !flush_valid;
   assign deq      = out_ready && !stall && clk_en && !flush_valid;
   assign n_deq    = (occupancy < OUT_C) ? occupancy : OUT_C;
   assign enq_cnt  = enq ? n_enq : '0;
   assign deq_cnt  = deq ? n_deq : '0;

   // Per-lane decode, truncation after the first taken lane, and compaction slots.
   always_comb begin
      cut        = 1'b0;
      n_enq      = '0;
      eff_mask   = '0;
      lane_taken = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         lane_dec[i]   = simple_decode(in_inst[i*32 +: 32]);
         lane_pc[i]    = in_pc + XLEN'(4 * i);
         wr_idx[i]     = tail + PTR_W'(n_enq);
         eff_mask[i]   = !cut && in_lane_mask[i];
         lane_taken[i] = eff_mask[i] && in_branch_jump[i];
         lane_pred[i]  = lane_taken[i] ? in_pred_next_adr : lane_pc[i] + XLEN'(4);
         if (eff_mask[i]) n_enq = n_enq + CNT_W'(1);
         if (lane_taken[i]) cut = 1'b1;
      end
   end

   // Queue storage: surviving lanes land in consecutive slots from tail; not reset.
   always_ff @(posedge clk) begin
      if (enq) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (eff_mask[i]) begin
               q_dec[wr_idx[i]]  <= lane_dec[i];
               q_pc[wr_idx[i]]   <= lane_pc[i];
               q_pred[wr_idx[i]] <= lane_pred[i];
               q_bj[wr_idx[i]]   <= lane_taken[i];
            end
         end
      end
   end

   // Head, tail and occupancy; flush overrides clk_en, reset overrides flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else if (flush_valid) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else if (clk_en) begin
         tail      <= tail + PTR_W'(enq_cnt);
         head      <= head + PTR_W'(deq_cnt);
         occupancy <= occupancy + enq_cnt - deq_cnt;
      end
   end

   // Present the OUT_WIDTH oldest slots; validity is a thermometer of occupancy.
   always_comb begin
      out_valid         = '0;
      out_pc            = '0;
      out_decoded       = '0;
      out_pred_next_adr = '0;
      out_branch_jump   = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         rd_idx[i]                          = head + PTR_W'(i);
         out_valid[i]                       = occupancy > CNT_W'(i);
         out_pc[i*XLEN +: XLEN]             = q_pc[rd_idx[i]];
         out_decoded[i*DEC_W +: DEC_W]      = q_dec[rd_idx[i]];
         out_pred_next_adr[i*XLEN +: XLEN]  = q_pred[rd_idx[i]];
         out_branch_jump[i]                 = q_bj[rd_idx[i]];
      end
   end

`ifdef DECODE1_PERF_CNT_EN
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   // Saturating counters: back-pressure cycles and entries discarded by flushes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_full_cycles   <= '0;
         perf_flushed_insts <= '0;
      end else begin
         if (clk_en && in_valid && !in_ready)
            perf_full_cycles <= sat_add32(perf_full_cycles, 32'd1);
         if (flush_valid)
            perf_flushed_insts <= sat_add32(perf_flushed_insts, 32'(occupancy));
      end
   end
`endif

endmodule

// File: tb/tb_decode1_buffered.sv
// Directed bench for decode1_buffered: a single-packet vector table plus
// hand-written sequences for fill, wrap, flush, stall/clk_en and async reset.
module tb_decode1_buffered;
   import decode1_pkg::*;

   localparam int DW = $bits(decode_instruction_t);

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en, stall, flush_valid, in_valid, out_ready;
   logic        in_ready;
   logic [1:0]  in_lane_mask, in_branch_jump;
   logic [63:0] in_inst;
   logic [31:0] in_pc, in_pred_next_adr;
   logic [1:0]  out_valid, out_branch_jump;
   logic [63:0] out_pc, out_pred_next_adr;
   logic [2*DW-1:0] out_decoded;
   logic [3:0]  occupancy;
`ifdef DECODE1_PERF_CNT_EN
   logic [31:0] perf_full_cycles, perf_flushed_insts;
   logic [31:0] d4_perf_full, d4_perf_flushed;
`endif

   // FETCH_WIDTH=4 instance for the truncation case
   logic        d4_in_valid, d4_in_ready;
   logic [3:0]  d4_mask, d4_bj;
   logic [127:0] d4_inst;
   logic [31:0] d4_pc, d4_pred;
   logic [1:0]  d4_out_valid, d4_out_bj;
   logic [63:0] d4_out_pc, d4_out_pred;
   logic [2*DW-1:0] d4_out_dec;
   logic [3:0]  d4_occ;

   decode_instruction_t d0, d1;
   assign d0 = out_decoded[DW-1:0];
   assign d1 = out_decoded[2*DW-1:DW];

   always #5 clk = ~clk;

   decode1_buffered #(.FETCH_WIDTH(2), .OUT_WIDTH(2), .DEPTH(8), .XLEN(32)) u_dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall), .flush_valid(flush_valid),
      .in_valid(in_valid), .in_ready(in_ready), .in_lane_mask(in_lane_mask),
      .in_inst(in_inst), .in_pc(in_pc), .in_pred_next_adr(in_pred_next_adr),
      .in_branch_jump(in_branch_jump), .out_ready(out_ready), .out_valid(out_valid),
      .out_pc(out_pc), .out_decoded(out_decoded), .out_pred_next_adr(out_pred_next_adr),
      .out_branch_jump(out_branch_jump),
`ifdef DECODE1_PERF_CNT_EN
      .perf_full_cycles(perf_full_cycles), .perf_flushed_insts(perf_flushed_insts),
`endif
      .occupancy(occupancy)
   );

   decode1_buffered #(.FETCH_WIDTH(4), .OUT_WIDTH(2), .DEPTH(8), .XLEN(32)) u_dut4 (
      .clk(clk), .rst(rst), .clk_en(1'b1), .stall(1'b0), .flush_valid(1'b0),
      .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_lane_mask(d4_mask),
      .in_inst(d4_inst), .in_pc(d4_pc), .in_pred_next_adr(d4_pred),
      .in_branch_jump(d4_bj), .out_ready(1'b0), .out_valid(d4_out_valid),
      .out_pc(d4_out_pc), .out_decoded(d4_out_dec), .out_pred_next_adr(d4_out_pred),
      .out_branch_jump(d4_out_bj),
`ifdef DECODE1_PERF_CNT_EN
      .perf_full_cycles(d4_perf_full), .perf_flushed_insts(d4_perf_flushed),
`endif
      .occupancy(d4_occ)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] mask, input logic [31:0] pc);
      in_valid     = 1'b1;
      in_lane_mask = mask;
      in_pc        = pc;
      step();
      in_valid     = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  mask;
      logic [1:0]  bj;
      logic [31:0] pc;
      logic [31:0] pred;
      logic [3:0]  e_occ;
      logic [1:0]  e_valid;
      logic [31:0] e_pc0;
      logic [31:0] e_pred0;
      logic [31:0] e_pc1;
      logic [31:0] e_pred1;
      logic [1:0]  e_bj;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{2'b11, 2'b00, 32'h100,  32'h999, 4'd2, 2'b11, 32'h100,  32'h104,  32'h104, 32'h108, 2'b00};
      vecs[1] = '{2'b11, 2'b01, 32'h300,  32'h500, 4'd1, 2'b01, 32'h300,  32'h500,  32'h0,   32'h0,   2'b01};
      vecs[2] = '{2'b11, 2'b10, 32'h40,   32'h80,  4'd2, 2'b11, 32'h40,   32'h44,   32'h44,  32'h80,  2'b10};
      vecs[3] = '{2'b10, 2'b00, 32'h1000, 32'h0,   4'd1, 2'b01, 32'h1004, 32'h1008, 32'h0,   32'h0,   2'b00};
      vecs[4] = '{2'b10, 2'b01, 32'h20,   32'hF00, 4'd1, 2'b01, 32'h24,   32'h28,   32'h0,   32'h0,   2'b00};
      vecs[5] = '{2'b00, 2'b11, 32'h50,   32'hF00, 4'd0, 2'b00, 32'h0,    32'h0,    32'h0,   32'h0,   2'b00};
      vecs[6] = '{2'b01, 2'b10, 32'h60,   32'h700, 4'd1, 2'b01, 32'h60,   32'h64,   32'h0,   32'h0,   2'b00};
      vecs[7] = '{2'b11, 2'b11, 32'h80,   32'hA00, 4'd1, 2'b01, 32'h80,   32'hA00,  32'h0,   32'h0,   2'b01};

      rst = 1'b0; clk_en = 1'b1; stall = 1'b0; flush_valid = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; in_lane_mask = 2'b00; in_branch_jump = 2'b00;
      in_inst = {32'hFFF00113, 32'h00500093}; in_pc = '0; in_pred_next_adr = 32'hDEAD;
      d4_in_valid = 1'b0; d4_mask = 4'b1111; d4_bj = 4'b0010; d4_inst = '0;
      d4_pc = 32'h200; d4_pred = 32'h400;

      // Reset state
      repeat (2) step();
      chk("reset_occ", 64'(occupancy), 64'd0);
      chk("reset_valid", 64'(out_valid), 64'd0);
      rst = 1'b1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      // First packet after reset, plus FETCH_WIDTH=4 truncation case
      d4_in_valid = 1'b1;
      send(2'b11, 32'h100);
      d4_in_valid = 1'b0;
      chk("p1_valid", 64'(out_valid), 64'b11);
      chk("p1_occ", 64'(occupancy), 64'd2);
      chk("p1_pc", out_pc, {32'h104, 32'h100});
      chk("p1_pred", out_pred_next_adr, {32'h108, 32'h104});
      chk("p1_bj", 64'(out_branch_jump), 64'b00);
      chk("p1_dec0_rd", 64'(d0.rd), 64'd1);
      chk("p1_dec0_imm", 64'($unsigned(d0.imm)), 64'h5);
      chk("p1_dec0_op", 64'(d0.opcode), 64'h13);
      chk("p1_dec1_rd", 64'(d1.rd), 64'd2);
      chk("p1_dec1_imm", 64'($unsigned(d1.imm)), 64'hFFFF_FFFF);
      chk("p1_dec1_illegal", 64'(d1.illegal), 64'd0);
      chk("fw4_occ", 64'(d4_occ), 64'd2);
      chk("fw4_valid", 64'(d4_out_valid), 64'b11);
      chk("fw4_pc", d4_out_pc, {32'h204, 32'h200});
      chk("fw4_pred", d4_out_pred, {32'h400, 32'h204});
      chk("fw4_bj", 64'(d4_out_bj), 64'b10);

      // Single-packet table, each from an empty queue
      for (int v = 0; v < 8; v++) begin
         flush_valid = 1'b1;
         step();
         flush_valid = 1'b0;
         in_branch_jump   = vecs[v].bj;
         in_pred_next_adr = vecs[v].pred;
         send(vecs[v].mask, vecs[v].pc);
         chk($sformatf("v%0d_occ", v), 64'(occupancy), 64'(vecs[v].e_occ));
         chk($sformatf("v%0d_valid", v), 64'(out_valid), 64'(vecs[v].e_valid));
         chk($sformatf("v%0d_bj", v), 64'(out_branch_jump & vecs[v].e_valid), 64'(vecs[v].e_bj));
         chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'd1);
         if (vecs[v].e_valid[0]) begin
            chk($sformatf("v%0d_pc0", v), 64'(out_pc[31:0]), 64'(vecs[v].e_pc0));
            chk($sformatf("v%0d_pred0", v), 64'(out_pred_next_adr[31:0]), 64'(vecs[v].e_pred0));
         end
         if (vecs[v].e_valid[1]) begin
            chk($sformatf("v%0d_pc1", v), 64'(out_pc[63:32]), 64'(vecs[v].e_pc1));
            chk($sformatf("v%0d_pred1", v), 64'(out_pred_next_adr[63:32]), 64'(vecs[v].e_pred1));
         end
      end
      in_branch_jump = 2'b00;

      // Fill to DEPTH, then a rejected packet
      rst = 1'b0; #1; rst = 1'b1;
      for (int i = 0; i < 4; i++) send(2'b11, 32'(8 * i));
      chk("fill_occ", 64'(occupancy), 64'd8);
      chk("fill_in_ready", 64'(in_ready), 64'd0);
      send(2'b11, 32'h20);
      chk("fill_reject_occ", 64'(occupancy), 64'd8);
      chk("fill_head_pc", 64'(out_pc[31:0]), 64'h0);
`ifdef DECODE1_PERF_CNT_EN
      chk("perf_full", 64'(perf_full_cycles), 64'd1);
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("fill_deq_occ", 64'(occupancy), 64'd6);
      chk("fill_deq_pc", 64'(out_pc[31:0]), 64'h8);

      // Streaming across the head wrap with simultaneous enqueue/dequeue
      flush_valid = 1'b1;
      step();
      flush_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_lane_mask = 2'b11; in_pc = 32'h1000 + 32'(8 * i);
         out_ready = 1'b1;
         step();
         chk($sformatf("wrap%0d_occ", i), 64'(occupancy), 64'd2);
         chk($sformatf("wrap%0d_pc", i), out_pc, {32'h1004 + 32'(8 * i), 32'h1000 + 32'(8 * i)});
      end
      in_valid = 1'b0; out_ready = 1'b0;

      // Flush with occupancy 6 and a competing packet
      rst = 1'b0; #1; rst = 1'b1;
      in_inst = '0;
      send(2'b11, 32'h10); send(2'b11, 32'h18); send(2'b11, 32'h20);
      chk("fl_pre_occ", 64'(occupancy), 64'd6);
      chk("fl_illegal", 64'(d0.illegal), 64'd1);
      flush_valid = 1'b1; out_ready = 1'b1;
      send(2'b11, 32'hBAD0);
      flush_valid = 1'b0; out_ready = 1'b0;
      chk("fl_occ", 64'(occupancy), 64'd0);
      chk("fl_valid", 64'(out_valid), 64'd0);
`ifdef DECODE1_PERF_CNT_EN
      chk("perf_flushed", 64'(perf_flushed_insts), 64'd6);
`endif
      step();
      chk("fl_after_occ", 64'(occupancy), 64'd0);
      send(2'b11, 32'h30);
      clk_en = 1'b0; flush_valid = 1'b1;
      step();
      clk_en = 1'b1; flush_valid = 1'b0;
      chk("fl_clken_occ", 64'(occupancy), 64'd0);

      // Stall and clk_en hold state
      send(2'b11, 32'h500);
      send(2'b01, 32'h600);
      chk("st_occ", 64'(occupancy), 64'd3);
      stall = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("stall%0d_occ", i), 64'(occupancy), 64'd3);
         chk($sformatf("stall%0d_pc", i), out_pc, {32'h504, 32'h500});
      end
      stall = 1'b0; clk_en = 1'b0; in_valid = 1'b1; in_pc = 32'h700;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("clken%0d_occ", i), 64'(occupancy), 64'd3);
         chk($sformatf("clken%0d_pc", i), 64'(out_pc[31:0]), 64'h500);
      end
      clk_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;

      // Asynchronous reset mid-cycle
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_occ", 64'(occupancy), 64'd0);
      rst = 1'b1;
      step();
      chk("arst_hold_occ", 64'(occupancy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
